// File: rtl/icache_pkg.sv
// Shared geometry and state encoding for the direct-mapped instruction cache.
// Address layout: {tag, index, word offset, byte lsb}.
package icache_pkg;

  localparam int ADDR_W      = 16;
  localparam int WORD_W      = 16;
  localparam int IDX_W       = 7;
  localparam int OFF_W       = 3;
  localparam int TAG_W       = ADDR_W - IDX_W - OFF_W - 1;
  localparam int BLOCK_BYTES = 16;
  localparam int NUM_BLOCKS_DEF      = 1 << IDX_W;
  localparam int WORDS_PER_BLOCK_DEF = BLOCK_BYTES / (WORD_W / 8);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// The cache is the slave; fetch unit plus memory together act as master.
interface icache_if;
  import icache_pkg::*;

  logic [ADDR_W-1:0] req_addr;
  logic              req_valid;
  logic [WORD_W-1:0] instr_out;
  logic              instr_valid;
  logic              stall;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [WORD_W-1:0] mem_data;
  logic              mem_data_valid;

  modport slave (
    input  req_addr, req_valid, mem_data, mem_data_valid,
    output instr_out, instr_valid, stall, mem_addr, mem_rd
  );

  modport master (
    output req_addr, req_valid, mem_data, mem_data_valid,
    input  instr_out, instr_valid, stall, mem_addr, mem_rd
  );

endinterface

// File: rtl/icache_fill_fsm.sv
// Block fill sequencer: issues one read per cycle for offsets 0..N-1 and
// counts returning words, which arrive in request order.
module icache_fill_fsm
  import icache_pkg::*;
#(
  parameter int TW = TAG_W,
  parameter int IW = IDX_W,
  parameter int OW = OFF_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  input  logic             lookup_hit_i,
  input  logic [TW-1:0]    req_tag_i,
  input  logic [IW-1:0]    req_idx_i,
  input  logic             mem_data_valid_i,
  output logic             fill_o,
  output logic             mem_rd_o,
  output logic [TW+IW+OW:0] mem_addr_o,
  output logic             data_we_o,
  output logic [IW-1:0]    fill_idx_o,
  output logic [OW-1:0]    fill_off_o,
  output logic             tag_we_o,
  output logic [TW-1:0]    fill_tag_o
);

  localparam logic [OW:0] CNT_ONE = (OW+1)'(1);

  fill_state_e   state_q, state_d;
  logic [TW-1:0] fill_tag_q, fill_tag_d;
  logic [IW-1:0] fill_idx_q, fill_idx_d;
  // Counters carry an extra done bit so the last offset needs no compare.
  logic [OW:0]   iss_q, iss_d;
  logic [OW:0]   rcv_q, rcv_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fill_tag_q <= '0;
      fill_idx_q <= '0;
      iss_q      <= '0;
      rcv_q      <= '0;
    end else begin
      state_q    <= state_d;
      fill_tag_q <= fill_tag_d;
      fill_idx_q <= fill_idx_d;
      iss_q      <= iss_d;
      rcv_q      <= rcv_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_tag_d = fill_tag_q;
    fill_idx_d = fill_idx_q;
    iss_d      = iss_q;
    rcv_d      = rcv_q;
    mem_rd_o   = 1'b0;
    data_we_o  = 1'b0;
    tag_we_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && !lookup_hit_i) begin
          state_d    = ST_FILL;
          fill_tag_d = req_tag_i;
          fill_idx_d = req_idx_i;
          iss_d      = '0;
          rcv_d      = '0;
        end
      end
      ST_FILL: begin
        if (!iss_q[OW]) begin
          mem_rd_o = 1'b1;
          iss_d    = iss_q + CNT_ONE;
        end
        if (mem_data_valid_i && !rcv_q[OW]) begin
          data_we_o = 1'b1;
          rcv_d     = rcv_q + CNT_ONE;
          if (&rcv_q[OW-1:0]) begin
            tag_we_o = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign fill_o     = (state_q == ST_FILL);
  assign mem_addr_o = {fill_tag_q, fill_idx_q, iss_q[OW-1:0], 1'b0};
  assign fill_idx_o = fill_idx_q;
  assign fill_off_o = rcv_q[OW-1:0];
  assign fill_tag_o = fill_tag_q;

endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with zero-latency hits and
// whole-block fills from a pipelined, in-order memory.
module icache
  import icache_pkg::*;
#(
  parameter int NUM_BLOCKS      = NUM_BLOCKS_DEF,
  parameter int WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF
) (
  input logic     clk,
  input logic     rst,
  icache_if.slave bus
);

  localparam int IW = $clog2(NUM_BLOCKS);
  localparam int OW = $clog2(WORDS_PER_BLOCK);
  localparam int TW = ADDR_W - IW - OW - 1;

  logic [TW-1:0]     tag_q  [NUM_BLOCKS];
  logic [WORD_W-1:0] data_q [NUM_BLOCKS][WORDS_PER_BLOCK];
  logic [NUM_BLOCKS-1:0] valid_q;

  logic [TW-1:0] req_tag;
  logic [IW-1:0] req_idx;
  logic [OW-1:0] req_off;
  logic          unused_lsb;

  assign req_tag    = bus.req_addr[ADDR_W-1 -: TW];
  assign req_idx    = bus.req_addr[OW+1 +: IW];
  assign req_off    = bus.req_addr[1 +: OW];
  assign unused_lsb = bus.req_addr[0];

  logic          lookup_hit, hit, fill;
  logic          data_we, tag_we;
  logic [IW-1:0] fill_idx;
  logic [OW-1:0] fill_off;
  logic [TW-1:0] fill_tag;

  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  // Lookups are suppressed while a fill owns the arrays.
  assign hit        = bus.req_valid && lookup_hit && !fill;

  assign bus.instr_valid = hit;
  assign bus.instr_out   = hit ? data_q[req_idx][req_off] : '0;
  assign bus.stall       = fill || (bus.req_valid && !lookup_hit);

  icache_fill_fsm #(
    .TW (TW),
    .IW (IW),
    .OW (OW)
  ) u_fill_fsm (
    .clk              (clk),
    .rst              (rst),
    .req_valid_i      (bus.req_valid),
    .lookup_hit_i     (lookup_hit),
    .req_tag_i        (req_tag),
    .req_idx_i        (req_idx),
    .mem_data_valid_i (bus.mem_data_valid),
    .fill_o           (fill),
    .mem_rd_o         (bus.mem_rd),
    .mem_addr_o       (bus.mem_addr),
    .data_we_o        (data_we),
    .fill_idx_o       (fill_idx),
    .fill_off_o       (fill_off),
    .tag_we_o         (tag_we),
    .fill_tag_o       (fill_tag)
  );

  always_ff @(posedge clk) begin
    if (data_we) data_q[fill_idx][fill_off] <= bus.mem_data;
  end

  always_ff @(posedge clk) begin
    if (tag_we) tag_q[fill_idx] <= fill_tag;
  end

  // Only the valid bits reset; stale tags/data are unreachable while invalid.
  always_ff @(posedge clk) begin
    if (rst)         valid_q           <= '0;
    else if (tag_we) valid_q[fill_idx] <= 1'b1;
  end

endmodule

// File: tb/tb_icache.sv
// Directed plus randomized bench for icache against a block-level cache model
// and a fixed-latency (4 cycle) in-order memory.
module tb_icache;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spur = 1'b0;
  logic [15:0] seed;

  icache_if bus ();
  icache dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [31:0] t;
    t = {16'h0, a ^ seed} * 32'h0000_9E37 + 32'h0000_05A5;
    return t[15:0] ^ t[31:16];
  endfunction

  // Memory: data for a read in cycle t is returned in cycle t+4.
  logic [3:0]       pv = '0;
  logic [3:0][15:0] pa = '0;
  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      pa <= '0;
    end else begin
      pv <= {pv[2:0], bus.mem_rd};
      pa <= {pa[2:0], bus.mem_addr};
    end
  end
  assign bus.mem_data_valid = pv[3] | spur;
  assign bus.mem_data       = spur ? 16'hDEAD : (pv[3] ? mem_word(pa[3]) : 16'h0000);

  // Cache model: which tag each block holds, if any.
  logic       mv [128];
  logic [4:0] mt [128];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  function automatic void m_clear();
    for (int i = 0; i < 128; i++) begin
      mv[i] = 1'b0;
      mt[i] = '0;
    end
  endfunction

  function automatic logic m_hit(input logic [15:0] a);
    return mv[a[10:4]] && (mt[a[10:4]] == a[15:11]);
  endfunction

  function automatic void m_fill(input logic [15:0] a);
    mv[a[10:4]] = 1'b1;
    mt[a[10:4]] = a[15:11];
    for (int k = 0; k < 8; k++) exp_q.push_back({a[15:4], 4'h0} + 16'(2 * k));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Request a1; after sw stall cycles the PC changes to a2. Returns once the
  // cache stops stalling and checks latency, fill reads and returned word.
  task automatic fetch(input string tag, input logic [15:0] a1, input int sw, input logic [15:0] a2);
    int   n;
    int   exp_st;
    bit   done;
    logic iv;
    logic [15:0] d;
    exp_q.delete();
    got_q.delete();
    exp_st = 0;
    if (!m_hit(a1)) begin m_fill(a1); exp_st += 13; end
    if (!m_hit(a2)) begin m_fill(a2); exp_st += 13; end
    bus.req_addr  = a1;
    bus.req_valid = 1'b1;
    n = 0;
    done = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (bus.mem_rd) got_q.push_back(bus.mem_addr);
      if (!bus.stall) begin
        done = 1'b1;
        break;
      end
      n++;
      @(posedge clk);
      #1;
      if (n == sw) bus.req_addr = a2;
    end
    iv = bus.instr_valid;
    d  = bus.instr_out;
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".stalls"}, n, exp_st);
    chk({tag, ".nrd"}, got_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < got_q.size()) chk({tag, ".rdaddr"}, 32'(got_q[i]), 32'(exp_q[i]));
    chk({tag, ".iv"}, 32'(iv), 32'd1);
    chk({tag, ".data"}, 32'(d), 32'(mem_word(a2)));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag, input int cycles);
    bus.req_valid = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      chk({tag, ".stall"}, 32'(bus.stall), 32'd0);
      chk({tag, ".iv"}, 32'(bus.instr_valid), 32'd0);
      chk({tag, ".out"}, 32'(bus.instr_out), 32'd0);
      chk({tag, ".rd"}, 32'(bus.mem_rd), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.req_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_clear();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [15:0] a;
    seed          = 16'($urandom);
    bus.req_addr  = 16'h0000;
    bus.req_valid = 1'b0;
    m_clear();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_chk("reset", 3);

    fetch("cold_miss", 16'h0000, -1, 16'h0000);
    for (int k = 1; k < 8; k++) fetch("seq_hit", 16'(2 * k), -1, 16'(2 * k));
    idle_chk("idle_cached", 2);

    fetch("conflict_a", 16'h0800, -1, 16'h0800);
    fetch("conflict_b", 16'h0000, -1, 16'h0000);
    fetch("conflict_c", 16'h0806, -1, 16'h0806);

    do_reset();
    fetch("pc_switch", 16'h0000, 4, 16'h1230);
    fetch("pc_switch_old", 16'h0004, -1, 16'h0004);

    // Abort a fill with reset six cycles into FILL.
    bus.req_addr  = 16'h0040;
    bus.req_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_clear();
    idle_chk("mid_fill_rst", 2);
    fetch("refill_after_rst", 16'h0040, -1, 16'h0040);
    fetch("old_block_gone", 16'h0002, -1, 16'h0002);

    spur = 1'b1;
    idle_chk("spurious", 3);
    spur = 1'b0;
    fetch("spur_keep_a", 16'h004A, -1, 16'h004A);
    fetch("spur_keep_b", 16'h000C, -1, 16'h000C);
    fetch("spur_miss", 16'h0850, -1, 16'h0850);

    for (int r = 0; r < 60; r++) begin
      if ($urandom_range(0, 3) == 0) idle_chk("rnd_idle", 1);
      a = {5'($urandom_range(0, 3)), 7'($urandom_range(0, 3)), 3'($urandom), 1'b0};
      fetch("rnd", a, -1, a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter NUM_BLOCKS, 128, direct-mapped block count (index width 7).
REQ-002 Parameter WORDS_PER_BLOCK, 8, 16-bit words per block (offset width 3; block = 16 bytes).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_addr  input  16  byte address from fetch (PC); bit 0 ignored.
REQ-006 req_valid  input  1  fetch requests an instruction this cycle.
REQ-007 instr_out  output  16  instruction word at req_addr; 16'h0000 when instr_valid low.
REQ-008 instr_valid  output  1  hit: instr_out valid this cycle (combinational).
REQ-009 stall  output  1  req_valid high and not hit; fetch holds PC.
REQ-010 mem_addr  output  16  word-aligned byte address of a fill read.
REQ-011 mem_rd  output  1  fill read issued this cycle; one request per cycle, pipelined.
REQ-012 mem_data  input  16  returned read data.
REQ-013 mem_data_valid  input  1  mem_data valid; returns in request order, fixed external latency.

Function
REQ-014 Address split: tag = req_addr[15:11], index = req_addr[10:4], offset = req_addr[3:1].
REQ-015 Hit = req_valid & valid[index] & (tag_array[index] == tag) & state IDLE; zero-cycle latency.
REQ-016 FSM states IDLE, FILL; IDLE -> FILL on req_valid & miss; FILL -> IDLE on edge where 8th word is written.
REQ-017 On IDLE->FILL: latch fill tag/index from req_addr; clear issue count and receive count (3-bit+done each).
REQ-018 In FILL: mem_rd high while issue count < 8; mem_addr = {fill tag, fill index, issue count, 1'b0}; issue count increments each such cycle.
REQ-019 Each mem_data_valid in FILL writes mem_data to data_array[fill index][receive count]; receive count increments.
REQ-020 With the 8th received word: write tag_array[fill index] = fill tag, set valid[fill index], go IDLE same edge.
REQ-021 Fill order always offset 0..7 (no critical-word-first); requesting word serviced by hit after fill.
REQ-022 req_addr changes during FILL ignored; fill completes for latched block; next IDLE cycle re-evaluates hit.
REQ-023 mem_data_valid while IDLE ignored; no array write.
REQ-024 req_valid low in IDLE: stall 0, instr_valid 0, no fill starts.
REQ-025 Fill overwrites victim block unconditionally (read-only cache, no writeback).
REQ-026 stall high in every FILL cycle and in the IDLE miss cycle; low otherwise.

Reset
REQ-027 rst: state IDLE, all valid bits 0, counters 0; mem_rd 0, stall 0, instr_valid 0, instr_out 0 in the cycle after.
REQ-028 Tag and data arrays not reset; contents irrelevant while valid = 0.
REQ-029 rst mid-FILL aborts fill, block left invalid; external memory shares rst and drops in-flight reads.

Structure
REQ-030 Shared package holds tag/index/offset widths, block size, state encoding.
REQ-031 One sub-module, icache_fill_fsm: state, counters, mem_rd/mem_addr, write enables; arrays and hit logic in icache.

Verification (memory model, latency 4)
REQ-032 After rst, req 0x0000: stall high 13 cycles, mem_rd 8 cycles at 0x0000..0x000E, then instr_valid with word 0.
REQ-033 After fill of 0x0000, req 0x0002..0x000E consecutive: instr_valid every cycle, stall 0, mem_rd 0.
REQ-034 Conflict: fill 0x0000, then req 0x0800 (same index, tag 1): refill; re-request 0x0000 misses again.
REQ-035 req_addr switched 0x0000 -> 0x1230 at fill cycle 3: fill completes for 0x0000 block, then 0x1230 miss starts.
REQ-036 rst at fill cycle 6, then req same address: full 13-cycle miss again, no stale data returned.
REQ-037 Spurious mem_data_valid in IDLE: arrays, valid bits, outputs unchanged.
